// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU arbiter slice.
package alu_pkg;
    localparam int DEF_WIDTH = 4;

    // Packed {m, s1, s0}
    typedef logic [2:0] alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: m=0 arithmetic (add, sub, inc A, dec A), m=1 logic (and, or, xor, not A).
module ALU #(
    parameter int WIDTH = 4
) (
    input  logic             m,
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_comb begin
        out = '0;
        case ({m, s1, s0})
            3'b000: out = A + B;
            3'b001: out = A - B;
            3'b010: out = A + ONE;
            3'b011: out = A - ONE;
            3'b100: out = A & B;
            3'b101: out = A | B;
            3'b110: out = A ^ B;
            3'b111: out = ~A;
            default: out = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters,
// one operation in flight at a time, registered result returned with its requester ID.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic [7:0]       op_count
);
    state_t           state;
    logic             last_grant;
    logic             grant;
    logic             accept;
    alu_op_t          op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] alu_out;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
    end

    assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state == IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;
    assign rsp_valid  = (state == RESP);

    ALU #(.WIDTH(WIDTH)) u_alu (
        .m   (op_r[2]),
        .s1  (op_r[1]),
        .s0  (op_r[0]),
        .A   (a_r),
        .B   (b_r),
        .out (alu_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            op_count   <= 8'd0;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r       <= grant ? req1_op : req0_op;
                        a_r        <= grant ? req1_a  : req0_a;
                        b_r        <= grant ? req1_b  : req0_b;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_out;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 8'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter against a transaction-queue reference model.
module tb_alu_arbiter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_data;
    logic         rsp_id;
    logic [7:0]   op_count;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int r;
        case (op)
            3'd0: r = int'(a) + int'(b);
            3'd1: r = int'(a) - int'(b);
            3'd2: r = int'(a) + 1;
            3'd3: r = int'(a) - 1;
            3'd4: r = int'(a & b);
            3'd5: r = int'(a | b);
            3'd6: r = int'(a ^ b);
            default: r = int'(~a);
        endcase
        return W'(r & ((1 << W) - 1));
    endfunction

    // Requester side: pending request held until the model says it was taken.
    logic         p0 = 1'b0, p1 = 1'b0;
    logic [2:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;

    // Reference model: at most one transaction in flight, visible from its due cycle.
    typedef struct { logic id; logic [W-1:0] data; int due; } txn_t;
    txn_t q[$];
    int   cyc = 0;
    logic m_last = 1'b1;
    int   m_cnt = 0;
    int   done_ops = 0;

    task automatic fill(input int pct);
        if (!p0 && $urandom_range(99) < pct) begin
            p0 = 1'b1; op0 = 3'($urandom); a0 = W'($urandom); b0 = W'($urandom);
        end
        if (!p1 && $urandom_range(99) < pct) begin
            p1 = 1'b1; op1 = 3'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        end
    endtask

    // Called just after a falling edge; checks this cycle, then advances one clock.
    task automatic step();
        logic idle, erv, e0, e1;
        txn_t t;
        req0_valid = p0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = p1; req1_op = op1; req1_a = a1; req1_b = b1;
        #1;
        idle = (q.size() == 0);
        erv  = !idle && (cyc >= q[0].due);
        e0   = !rst && idle && p0 && (!p1 || m_last == 1'b1);
        e1   = !rst && idle && p1 && (!p0 || m_last == 1'b0);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("rsp_valid", rsp_valid, erv);
        if (erv) begin
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_id", rsp_id, q[0].id);
        end
        chk("op_count", op_count, 32'(m_cnt));
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_last = 1'b1;
            m_cnt  = 0;
            done_ops = 0;
        end else if (erv && rsp_ready) begin
            void'(q.pop_front());
            m_cnt = (m_cnt + 1) % 256;
            done_ops++;
        end else if (e0 || e1) begin
            t.id   = e1;
            t.data = e1 ? alu_ref(op1, a1, b1) : alu_ref(op0, a0, b0);
            t.due  = cyc + 2;
            q.push_back(t);
            m_last = e1;
        end
        if (e0) p0 = 1'b0;
        if (e1) p1 = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
    endtask

    initial begin
        int n;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        // Power-up reset, with both requesters asking so readies are exercised.
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_op_count", op_count, 0);
        do_reset();

        // Single request from requester 0.
        p0 = 1'b1; op0 = 3'b000; a0 = 4'b1010; b0 = 4'b0111; rsp_ready = 1'b1;
        repeat (5) step();
        chk("single_count", op_count, 1);

        // Tie: both always pending, grants must alternate.
        for (int i = 0; i < 12; i++) begin
            fill(100);
            step();
        end

        // Backpressure: hold rsp_ready low while a response sits in RESP.
        p1 = 1'b1; op1 = 3'b110; a1 = 4'b1010; b1 = 4'b0111; p0 = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) step();
        p0 = 1'b1; op0 = 3'b001; a0 = 4'b0011; b0 = 4'b0101;
        repeat (5) step();
        rsp_ready = 1'b1;
        repeat (6) step();

        // Sweep every op through requester 1.
        for (int k = 0; k < 8; k++) begin
            p1 = 1'b1; op1 = 3'(k); a1 = 4'b1010; b1 = 4'b0111;
            repeat (3) step();
        end

        // Reset while the operation is in EXEC.
        do_reset();
        p0 = 1'b1; op0 = 3'b101; a0 = 4'b1100; b0 = 4'b0011;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_op_count", op_count, 0);
        p0 = 1'b1; p1 = 1'b1;
        op0 = 3'b010; a0 = 4'b0001; op1 = 3'b011; a1 = 4'b0001;
        repeat (4) step();

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            fill(40);
            rsp_ready = ($urandom_range(3) != 0);
            step();
        end
        rsp_ready = 1'b1;

        // Counter wrap: exactly 256 completions from reset.
        do_reset();
        n = 0;
        while (done_ops < 256 && n < 3000) begin
            fill(70);
            step();
            n++;
        end
        if (done_ops < 256) chk("wrap_timeout", 32'(done_ops), 256);
        chk("wrap_op_count", op_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
